// File: rtl/branch_predictor_if.sv
// Predictor <-> pipeline bundle: ID lookup inputs, MEM resolve inputs, prediction/recovery outputs.
// master = pipeline/decoder side; slave = branch_predictor.
interface branch_predictor_if;
    logic        stall;
    logic        flush;
    logic [31:0] pc_id;
    logic [31:0] imm_id;
    logic        branch_early;
    logic        jump_early;
    logic        branch_resolved;
    logic        actual_taken;
    logic        predict_taken_id;
    logic [31:0] predict_target_id;
    logic        jump_taken;
    logic        mispredict_nt;
    logic [31:0] recover_pc;
    logic [31:0] branch_count;
    logic [31:0] mispredict_count;

    modport master (
        output stall, flush, pc_id, imm_id, branch_early, jump_early,
               branch_resolved, actual_taken,
        input  predict_taken_id, predict_target_id, jump_taken, mispredict_nt,
               recover_pc, branch_count, mispredict_count
    );

    modport slave (
        input  stall, flush, pc_id, imm_id, branch_early, jump_early,
               branch_resolved, actual_taken,
        output predict_taken_id, predict_target_id, jump_taken, mispredict_nt,
               recover_pc, branch_count, mispredict_count
    );
endinterface

// File: rtl/branch_predictor.sv
// 2-bit saturating-counter predictor: zero-latency ID lookup, prediction tracked through EX/MEM (2 unstalled edges).
// No backpressure of its own: stall inserts an EX bubble, flush squashes EX/MEM tracking, training is never gated.
module branch_predictor #(
    parameter int         INDEX_BITS = 6,
    parameter logic [1:0] INIT_STATE = 2'b01
) (
    input  logic            i_clk,
    input  logic            i_rst,
    branch_predictor_if.slave bp
);
    localparam int ENTRIES = 1 << INDEX_BITS;

    typedef struct packed {
        logic                  vld;
        logic                  is_br;
        logic                  pred;
        logic [INDEX_BITS-1:0] idx;
        logic [31:0]           pc;
    } slot_t;

    logic [1:0]            r_table [ENTRIES];
    slot_t                 r_ex;
    slot_t                 r_mem;
    logic [31:0]           r_branch_count;
    logic [31:0]           r_mispredict_count;

    logic [INDEX_BITS-1:0] w_idx_id;
    logic                  w_pred_id;
    slot_t                 w_id_slot;
    logic                  w_train;
    logic                  w_wrong;
    logic [1:0]            w_cur_ctr;

    assign w_idx_id  = bp.pc_id[INDEX_BITS+1:2];
    // JALR never asserts jump_early, so its unknown target is never predicted.
    assign w_pred_id = bp.jump_early | (bp.branch_early & r_table[w_idx_id][1]);
    assign w_id_slot = '{vld:   bp.branch_early | bp.jump_early,
                         is_br: bp.branch_early,
                         pred:  w_pred_id,
                         idx:   w_idx_id,
                         pc:    bp.pc_id};

    assign w_train   = bp.branch_resolved & r_mem.vld & r_mem.is_br;
    assign w_wrong   = r_mem.pred != bp.actual_taken;
    assign w_cur_ctr = r_table[r_mem.idx];

    assign bp.predict_taken_id  = w_pred_id;
    assign bp.predict_target_id = bp.pc_id + bp.imm_id;
    assign bp.jump_taken        = r_mem.vld & r_mem.pred;
    assign bp.mispredict_nt     = w_train & r_mem.pred & ~bp.actual_taken;
    assign bp.recover_pc        = r_mem.pc + 32'd4;
    assign bp.branch_count      = r_branch_count;
    assign bp.mispredict_count  = r_mispredict_count;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_ex  <= '0;
            r_mem <= '0;
        end else if (bp.flush) begin
            r_ex  <= '0;
            r_mem <= '0;
        end else if (bp.stall) begin
            r_ex  <= '0;
            r_mem <= r_ex;
        end else begin
            r_ex  <= w_id_slot;
            r_mem <= r_ex;
        end
    end

    // No bypass: an ID lookup of the index being trained this cycle sees the old counter.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                r_table[i] <= INIT_STATE;
            end
        end else if (w_train) begin
            if (bp.actual_taken) begin
                if (w_cur_ctr != 2'b11) begin
                    r_table[r_mem.idx] <= w_cur_ctr + 2'd1;
                end
            end else if (w_cur_ctr != 2'b00) begin
                r_table[r_mem.idx] <= w_cur_ctr - 2'd1;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_branch_count     <= '0;
            r_mispredict_count <= '0;
        end else if (w_train) begin
            r_branch_count <= r_branch_count + 32'd1;
            if (w_wrong) begin
                r_mispredict_count <= r_mispredict_count + 32'd1;
            end
        end
    end
endmodule

// File: tb/tb_branch_predictor.sv
// Bench for branch_predictor: hand-derived vector table, directed flush/stall/wrap/reset sequences,
// then random traffic scored against a per-entry counter model of the predictor.
module tb_branch_predictor;
    logic clk;
    logic rst;

    branch_predictor_if bpi ();

    branch_predictor #(.INDEX_BITS(6), .INIT_STATE(2'b01)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bp    (bpi)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit          rst;
        bit          stall;
        bit          flush;
        bit          br;
        bit          jmp;
        bit          res;
        bit          act;
        logic [31:0] pc;
        logic [31:0] imm;
    } stim_t;

    typedef struct {
        stim_t       s;
        bit          pt;
        logic [31:0] tgt;
        bit          jt;
        bit          mnt;
        logic [31:0] rpc;
        logic [31:0] bc;
        logic [31:0] mc;
    } vec_t;

    typedef struct {
        bit          v;
        bit          br;
        bit          pred;
        int          idx;
        logic [31:0] pc;
    } mslot_t;

    int          n_cmp  = 0;
    int          n_fail = 0;

    // Reference model: one small integer counter per entry plus the two in-flight records.
    int          m_tbl [64];
    mslot_t      m_ex;
    mslot_t      m_mem;
    logic [31:0] m_bc;
    logic [31:0] m_mc;

    function automatic int idx_of(input logic [31:0] pc);
        return int'((pc >> 2) % 32'd64);
    endfunction

    function automatic stim_t S(input bit br, input bit jmp, input bit res, input bit act,
                                input logic [31:0] pc, input logic [31:0] imm);
        stim_t s;
        s = '{rst: 1'b0, stall: 1'b0, flush: 1'b0, br: br, jmp: jmp, res: res, act: act,
              pc: pc, imm: imm};
        return s;
    endfunction

    function automatic vec_t V(input stim_t s, input bit pt, input logic [31:0] tgt, input bit jt,
                               input bit mnt, input logic [31:0] rpc, input logic [31:0] bc,
                               input logic [31:0] mc);
        vec_t v;
        v = '{s: s, pt: pt, tgt: tgt, jt: jt, mnt: mnt, rpc: rpc, bc: bc, mc: mc};
        return v;
    endfunction

    task automatic cmp(input string nm, input logic [31:0] a, input logic [31:0] e);
        n_cmp++;
        if (a !== e) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", nm, a, e, $time);
        end
    endtask

    task automatic apply(input stim_t s);
        rst                 = s.rst;
        bpi.stall           = s.stall;
        bpi.flush           = s.flush;
        bpi.branch_early    = s.br;
        bpi.jump_early      = s.jmp;
        bpi.branch_resolved = s.res;
        bpi.actual_taken    = s.act;
        bpi.pc_id           = s.pc;
        bpi.imm_id          = s.imm;
        #1;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 64; i++) m_tbl[i] = 1;
        m_ex  = '{v: 1'b0, br: 1'b0, pred: 1'b0, idx: 0, pc: 32'd0};
        m_mem = m_ex;
        m_bc  = 32'd0;
        m_mc  = 32'd0;
    endtask

    function automatic bit model_pred(input stim_t s);
        return s.jmp || (s.br && m_tbl[idx_of(s.pc)] >= 2);
    endfunction

    task automatic model_update(input stim_t s);
        mslot_t id_rec;
        bit     train;
        id_rec = '{v: s.br | s.jmp, br: s.br, pred: model_pred(s), idx: idx_of(s.pc), pc: s.pc};
        train  = s.res && m_mem.v && m_mem.br;
        if (s.rst) begin
            model_reset();
        end else begin
            if (train) begin
                if (s.act) m_tbl[m_mem.idx] = (m_tbl[m_mem.idx] == 3) ? 3 : m_tbl[m_mem.idx] + 1;
                else       m_tbl[m_mem.idx] = (m_tbl[m_mem.idx] == 0) ? 0 : m_tbl[m_mem.idx] - 1;
                m_bc = m_bc + 32'd1;
                if (m_mem.pred != s.act) m_mc = m_mc + 32'd1;
            end
            if (s.flush) begin
                m_ex.v  = 1'b0;
                m_mem.v = 1'b0;
            end else if (s.stall) begin
                m_mem  = m_ex;
                m_ex.v = 1'b0;
            end else begin
                m_mem = m_ex;
                m_ex  = id_rec;
            end
        end
    endtask

    task automatic model_cmp(input stim_t s);
        bit mnt;
        mnt = s.res && m_mem.v && m_mem.br && m_mem.pred && !s.act;
        cmp("predict_taken_id", 32'(bpi.predict_taken_id), 32'(model_pred(s)));
        cmp("predict_target_id", bpi.predict_target_id, s.pc + s.imm);
        cmp("jump_taken", 32'(bpi.jump_taken), 32'(m_mem.v && m_mem.pred));
        cmp("mispredict_nt", 32'(bpi.mispredict_nt), 32'(mnt));
        if (mnt) cmp("recover_pc", bpi.recover_pc, m_mem.pc + 32'd4);
        cmp("branch_count", bpi.branch_count, m_bc);
        cmp("mispredict_count", bpi.mispredict_count, m_mc);
    endtask

    task automatic finish_cycle(input stim_t s);
        @(posedge clk);
        model_update(s);
        @(negedge clk);
    endtask

    task automatic step(input stim_t s, input bit chk);
        apply(s);
        if (chk) model_cmp(s);
        finish_cycle(s);
    endtask

    vec_t  vt [23];
    stim_t s;
    stim_t idle;

    initial begin
        idle = S(0, 0, 0, 0, 32'h0, 32'h0);
        // Plan walk-through: the 0x100 and 0x200 branches alias onto entry 0.
        vt[0]  = V(idle,                                 0, 32'h0,   0, 0, 32'h0,   0, 0);
        vt[1]  = V(S(1, 0, 0, 0, 32'h100, 32'h20),       0, 32'h120, 0, 0, 32'h0,   0, 0);
        vt[2]  = V(idle,                                 0, 32'h0,   0, 0, 32'h0,   0, 0);
        vt[3]  = V(S(0, 0, 1, 1, 32'h0, 32'h0),          0, 32'h0,   0, 0, 32'h0,   0, 0);
        vt[4]  = V(idle,                                 0, 32'h0,   0, 0, 32'h0,   1, 1);
        vt[5]  = V(S(1, 0, 0, 0, 32'h100, 32'h20),       1, 32'h120, 0, 0, 32'h0,   1, 1);
        vt[6]  = V(idle,                                 0, 32'h0,   0, 0, 32'h0,   1, 1);
        vt[7]  = V(S(0, 0, 1, 1, 32'h0, 32'h0),          0, 32'h0,   1, 0, 32'h0,   1, 1);
        vt[8]  = V(S(1, 0, 0, 0, 32'h100, 32'h20),       1, 32'h120, 0, 0, 32'h0,   2, 1);
        vt[9]  = V(idle,                                 0, 32'h0,   0, 0, 32'h0,   2, 1);
        vt[10] = V(S(0, 0, 1, 1, 32'h0, 32'h0),          0, 32'h0,   1, 0, 32'h0,   2, 1);
        vt[11] = V(S(1, 0, 0, 0, 32'h100, 32'h20),       1, 32'h120, 0, 0, 32'h0,   3, 1);
        vt[12] = V(idle,                                 0, 32'h0,   0, 0, 32'h0,   3, 1);
        vt[13] = V(S(0, 0, 1, 1, 32'h0, 32'h0),          0, 32'h0,   1, 0, 32'h0,   3, 1);
        vt[14] = V(S(1, 0, 0, 0, 32'h200, 32'h0),        1, 32'h200, 0, 0, 32'h0,   4, 1);
        vt[15] = V(idle,                                 0, 32'h0,   0, 0, 32'h0,   4, 1);
        vt[16] = V(S(0, 0, 1, 0, 32'h0, 32'h0),          0, 32'h0,   1, 1, 32'h204, 4, 1);
        vt[17] = V(S(1, 0, 0, 0, 32'h100, 32'h20),       1, 32'h120, 0, 0, 32'h0,   5, 2);
        vt[18] = V(idle,                                 0, 32'h0,   0, 0, 32'h0,   5, 2);
        vt[19] = V(S(0, 1, 0, 0, 32'h300, 32'hFFFFFFF0), 1, 32'h2F0, 1, 0, 32'h0,   5, 2);
        vt[20] = V(idle,                                 0, 32'h0,   0, 0, 32'h0,   5, 2);
        vt[21] = V(S(0, 0, 1, 1, 32'h0, 32'h0),          0, 32'h0,   1, 0, 32'h0,   5, 2);
        vt[22] = V(idle,                                 0, 32'h0,   0, 0, 32'h0,   5, 2);

        model_reset();
        s     = idle;
        s.rst = 1'b1;
        apply(s);
        @(negedge clk);
        step(s, 1'b0);
        step(s, 1'b0);

        foreach (vt[i]) begin
            apply(vt[i].s);
            cmp($sformatf("vec%0d predict_taken_id", i), 32'(bpi.predict_taken_id), 32'(vt[i].pt));
            cmp($sformatf("vec%0d predict_target_id", i), bpi.predict_target_id, vt[i].tgt);
            cmp($sformatf("vec%0d jump_taken", i), 32'(bpi.jump_taken), 32'(vt[i].jt));
            cmp($sformatf("vec%0d mispredict_nt", i), 32'(bpi.mispredict_nt), 32'(vt[i].mnt));
            if (vt[i].mnt) cmp($sformatf("vec%0d recover_pc", i), bpi.recover_pc, vt[i].rpc);
            cmp($sformatf("vec%0d branch_count", i), bpi.branch_count, vt[i].bc);
            cmp($sformatf("vec%0d mispredict_count", i), bpi.mispredict_count, vt[i].mc);
            finish_cycle(vt[i].s);
        end

        // Flushed branch in EX: never reaches MEM, never trains (a wrong decrement would drop entry 0 to 01).
        step(S(1, 0, 0, 0, 32'h100, 32'h20), 1'b1);
        s = idle; s.flush = 1'b1;
        step(s, 1'b1);
        apply(idle);
        cmp("flush jump_taken", 32'(bpi.jump_taken), 32'd0);
        finish_cycle(idle);
        s = S(0, 0, 1, 0, 32'h0, 32'h0);
        apply(s);
        cmp("flush jump_taken@mem", 32'(bpi.jump_taken), 32'd0);
        cmp("flush mispredict_nt", 32'(bpi.mispredict_nt), 32'd0);
        finish_cycle(s);
        s = S(1, 0, 0, 0, 32'h100, 32'h20);
        apply(s);
        cmp("flush entry untrained", 32'(bpi.predict_taken_id), 32'd1);
        cmp("flush branch_count", bpi.branch_count, 32'd5);
        finish_cycle(s);
        for (int i = 0; i < 3; i++) step(idle, 1'b1);

        // Stalled ID branch: bubble in EX, branch reaches MEM one cycle late.
        s = S(1, 0, 0, 0, 32'h100, 32'h20); s.stall = 1'b1;
        step(s, 1'b1);
        step(S(1, 0, 0, 0, 32'h100, 32'h20), 1'b1);
        apply(idle);
        cmp("stall bubble jump_taken", 32'(bpi.jump_taken), 32'd0);
        finish_cycle(idle);
        s = S(0, 0, 1, 1, 32'h0, 32'h0);
        apply(s);
        cmp("stall late jump_taken", 32'(bpi.jump_taken), 32'd1);
        finish_cycle(s);
        step(idle, 1'b1);

        // branch_count wrap.
        step(S(1, 0, 0, 0, 32'h100, 32'h20), 1'b1);
        force dut.r_branch_count = 32'hFFFF_FFFF;
        #1;
        release dut.r_branch_count;
        m_bc = 32'hFFFF_FFFF;
        step(idle, 1'b1);
        step(S(0, 0, 1, 1, 32'h0, 32'h0), 1'b1);
        apply(idle);
        cmp("branch_count wrap", bpi.branch_count, 32'd0);
        finish_cycle(idle);

        // Reset coincident with a resolving branch: training dropped, all state back to reset values.
        step(S(1, 0, 0, 0, 32'h100, 32'h20), 1'b1);
        step(idle, 1'b1);
        s = S(0, 0, 1, 1, 32'h0, 32'h0); s.rst = 1'b1;
        step(s, 1'b1);
        s = S(1, 0, 0, 0, 32'h100, 32'h20);
        apply(s);
        cmp("rst entry back to INIT", 32'(bpi.predict_taken_id), 32'd0);
        cmp("rst jump_taken", 32'(bpi.jump_taken), 32'd0);
        cmp("rst branch_count", bpi.branch_count, 32'd0);
        cmp("rst mispredict_count", bpi.mispredict_count, 32'd0);
        finish_cycle(s);
        for (int i = 0; i < 3; i++) step(idle, 1'b1);

        // Random traffic over a small PC window so entries alias and saturate both ways.
        for (int i = 0; i < 800; i++) begin
            int r;
            s       = idle;
            r       = int'($urandom_range(0, 99));
            s.br    = r < 45;
            s.jmp   = (r >= 45) && (r < 55);
            s.pc    = {22'd0, 8'($urandom_range(0, 255)), 2'b00};
            s.imm   = $urandom;
            s.res   = $urandom_range(0, 99) < 50;
            s.act   = $urandom_range(0, 1) == 1;
            s.stall = $urandom_range(0, 99) < 10;
            s.flush = $urandom_range(0, 99) < 5;
            s.rst   = $urandom_range(0, 299) == 0;
            step(s, 1'b1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/branch_predictor.md
# branch_predictor

Dynamic branch predictor for the 5-stage RISC-V pipeline. Looks up a 2-bit saturating-counter table in ID to redirect fetch for predicted-taken branches and JAL. Carries each prediction down to MEM, where the decoder resolves the branch. Drives `jump_taken` back to the decoder, trains the table from `branch_resolved`/`actual_taken`, and raises a recovery redirect when a predicted-taken branch falls through.

## Interface
- `INDEX_BITS`, 6, table index width; entries = 2^INDEX_BITS, indexed by `pc[INDEX_BITS+1:2]`
- `INIT_STATE`, 2'b01, counter value loaded into every entry on reset (weakly not-taken)
- `clk` input 1: single clock; all state on posedge
- `rst` input 1: synchronous, active-high reset
- `stall` input 1: load-use stall; ID holds, bubble enters EX
- `flush` input 1: squash ID and EX instructions (decoder `flushOut != 0`)
- `pc_id` input 32: PC of instruction in ID
- `imm_id` input 32: generated immediate of instruction in ID
- `branch_early` input 1: ID instruction is a conditional branch
- `jump_early` input 1: ID instruction is JAL
- `branch_resolved` input 1: MEM instruction is a branch, outcome valid this cycle
- `actual_taken` input 1: resolved outcome of MEM branch
- `predict_taken_id` output 1: redirect fetch to `predict_target_id`
- `predict_target_id` output 32: `pc_id + imm_id`, modulo 2^32
- `jump_taken` output 1: MEM instruction was predicted taken; decoder suppresses PCSel
- `mispredict_nt` output 1: MEM branch predicted taken, resolved not-taken
- `recover_pc` output 32: `pc_mem + 4`, valid when `mispredict_nt`
- `branch_count` output 32: resolved conditional branches since reset
- `mispredict_count` output 32: mispredicted conditional branches since reset

## Operation
- Counter encoding: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T. Predict taken iff bit 1 = 1.
- ID lookup (combinational): `predict_taken_id = jump_early | (branch_early & table[idx_id][1])`. JALR is never predicted (target unknown in ID).
- Tracking slots EX and MEM each hold {valid, is_branch, pred, idx, pc}.
- Slot advance on posedge, in priority order:
  - `rst`: both slots invalid.
  - `flush`: both slots invalid. Flush has priority over stall.
  - `stall`: EX ← invalid; MEM ← EX.
  - Otherwise: EX ← ID (valid iff `branch_early | jump_early`); MEM ← EX.
- `jump_taken = mem.valid & mem.pred`.
- Training: when `branch_resolved & mem.valid & mem.is_branch`:
  - `table[mem.idx]` increments on `actual_taken`, saturating at 11.
  - Otherwise decrements, saturating at 00.
  - Not gated by stall or flush.
- `mispredict_nt = branch_resolved & mem.valid & mem.is_branch & mem.pred & ~actual_taken`. Fetch must honour `recover_pc` and flush ID/EX.
- Predicted-NT but actually-taken needs no action here; the decoder's PCSel handles it.
- Counters, on each training event:
  - `branch_count` += 1.
  - `mispredict_count` += 1 when `mem.pred != actual_taken`.
  - Both wrap 0xFFFFFFFF → 0. Jumps are not counted.
- `branch_resolved` with an invalid MEM slot: no training, no count, no mispredict.

## Timing
- Reset values:
  - all table entries = `INIT_STATE`
  - slots invalid
  - `branch_count` = `mispredict_count` = 0
  - `jump_taken` = `mispredict_nt` = 0
  - `predict_taken_id` = 0 unless ID inputs assert
- Reset asserted mid-operation clears everything on that edge. Training requested in the same cycle is dropped.
- `predict_taken_id` and `predict_target_id`: zero latency from ID inputs.
- Prediction visible as `jump_taken` exactly 2 unstalled edges after ID, or later if stalls insert bubbles.
- Table write takes effect on the edge ending the resolve cycle.
- Same-cycle lookup and update of one index: lookup returns the pre-update value; no bypass.
- `mispredict_nt`, `recover_pc`, and `jump_taken` are combinational from MEM slot and inputs. Counter outputs are registered.

## Test plan
- Reset, then `branch_early=1`, `pc_id=0x100`, `imm_id=0x20` → `predict_taken_id=0`, `predict_target_id=0x120`. Two edges later, `branch_resolved=1`, `actual_taken=1` → `jump_taken=0`, entry 0x100 becomes 10, `branch_count=1`, `mispredict_count=1`.
- Repeat the same branch taken 4× → predictions 0, 1, 1, 1; counter saturates at 11; no wrap to 00.
- Entry at 11, branch at 0x200 resolves not-taken → `jump_taken=1`, `mispredict_nt=1`, `recover_pc=0x204`, entry becomes 10.
- JAL at 0x300 with `imm_id=0xFFFFFFF0` → `predict_taken_id=1`, target 0x2F0, `jump_taken=1` in MEM, counters unchanged.
- Branch in EX and `flush=1` → that branch never asserts `jump_taken` or trains. Stall with a branch in ID → EX bubble, branch reaches MEM one cycle later.
- Force `branch_count=0xFFFFFFFF`, resolve one branch → `branch_count=0`. `rst=1` coincident with `branch_resolved` → no training, all outputs at reset values.
